// File: rtl/piezo_tone_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : piezo_tone_seq_if
// Purpose  : Note-stream handshake between the tune controller (master) and
//            the piezo tone sequencer (slave).
// Signals  : note_vld  master->slave  a note is offered
//            note_rdy  slave->master  the note FIFO can accept a note
//            note_per  master->slave  half-period minus 1 in cycles, 0 = rest
//            note_dur  master->slave  note length in cycles, 0 treated as 1
// Revision : 1.0  initial release
// ============================================================================
interface piezo_tone_seq_if #(
    parameter int PER_W = 15,
    parameter int DUR_W = 24
) ();
    logic             note_vld;
    logic             note_rdy;
    logic [PER_W-1:0] note_per;
    logic [DUR_W-1:0] note_dur;

    modport master (
        output note_vld,
        output note_per,
        output note_dur,
        input  note_rdy
    );

    modport slave (
        input  note_vld,
        input  note_per,
        input  note_dur,
        output note_rdy
    );
endinterface
`default_nettype wire

// File: rtl/piezo_tone_seq.sv
`default_nettype none
// ============================================================================
// Module   : piezo_tone_seq
// Purpose  : Buffers (period, duration) notes in a small FIFO and plays them
//            back-to-back on a complementary piezo drive pair, with rests,
//            a synchronous abort/flush and a per-note completion pulse.
// Ports    : clk        system clock, rising edge
//            rst        synchronous active-high reset
//            clr        synchronous abort and flush
//            note_if    slave side of the note handshake
//            piezo      drive A (registered)
//            piezo_n    drive B (registered)
//            busy       a note is playing or the FIFO holds notes
//            note_done  one-cycle pulse when a played note finishes
//            fifo_cnt   FIFO occupancy
// Params   : PER_W, DUR_W field widths; DEPTH FIFO depth (power of 2, >= 2)
// Revision : 1.0  initial release
// ============================================================================
module piezo_tone_seq #(
    parameter int PER_W = 15,
    parameter int DUR_W = 24,
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       clr,
    piezo_tone_seq_if.slave                 note_if,
    output logic                            piezo,
    output logic                            piezo_n,
    output logic                            busy,
    output logic                            note_done,
    output logic [$clog2(DEPTH+1)-1:0]      fifo_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // FIFO storage and bookkeeping
    logic [PER_W-1:0] r_mem_per [DEPTH];
    logic [DUR_W-1:0] r_mem_dur [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;

    // Current note and its counters
    logic [PER_W-1:0] r_per;
    logic [PER_W-1:0] w_per_nxt;
    logic [DUR_W-1:0] r_dur;
    logic [DUR_W-1:0] w_dur_nxt;
    logic [PER_W-1:0] r_freq_cnt;
    logic [PER_W-1:0] w_freq_nxt;
    logic [DUR_W-1:0] r_dur_cnt;
    logic [DUR_W-1:0] w_dur_cnt_nxt;

    logic             r_piezo;
    logic             w_piezo_nxt;
    logic             r_piezo_n;
    logic             w_piezo_n_nxt;
    logic             r_done;
    logic             w_done_nxt;

    logic             w_abort;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [PER_W-1:0] w_head_per;
    logic [DUR_W-1:0] w_head_dur;

    assign w_abort          = rst | clr;
    assign w_full           = (r_cnt == c_full_cnt);
    assign w_empty          = (r_cnt == '0);
    // Ready ignores a concurrent pop so a full FIFO never takes a note.
    assign note_if.note_rdy = !w_full && !w_abort;
    assign w_push           = note_if.note_vld && note_if.note_rdy;
    assign w_head_per       = r_mem_per[r_rd_ptr];
    assign w_head_dur       = r_mem_dur[r_rd_ptr];

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_abort) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and datapath next values
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_per_nxt     = r_per;
        w_dur_nxt     = r_dur;
        w_freq_nxt    = r_freq_cnt;
        w_dur_cnt_nxt = r_dur_cnt;
        w_piezo_nxt   = r_piezo;
        w_piezo_n_nxt = r_piezo_n;
        w_done_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_piezo_nxt   = 1'b0;
                w_piezo_n_nxt = 1'b0;
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_per_nxt     = w_head_per;
                    // Store the effective length so the end test is a plain
                    // equality and the counter can never pass the stored value.
                    w_dur_nxt     = (w_head_dur == '0) ? DUR_W'(1) : w_head_dur;
                    w_freq_nxt    = '0;
                    w_dur_cnt_nxt = DUR_W'(1);
                    w_piezo_nxt   = (w_head_per != '0);
                    w_piezo_n_nxt = 1'b0;
                    w_state_nxt   = S_PLAY;
                end
            end

            S_PLAY: begin
                if (r_dur_cnt == r_dur) begin
                    // Note end wins over any half-period toggle on this edge.
                    w_state_nxt   = S_IDLE;
                    w_piezo_nxt   = 1'b0;
                    w_piezo_n_nxt = 1'b0;
                    w_done_nxt    = 1'b1;
                end else begin
                    w_dur_cnt_nxt = r_dur_cnt + DUR_W'(1);
                    if (r_per != '0) begin
                        if (r_freq_cnt == r_per) begin
                            w_freq_nxt    = '0;
                            w_piezo_nxt   = ~r_piezo;
                            w_piezo_n_nxt = r_piezo;
                        end else begin
                            w_freq_nxt    = r_freq_cnt + PER_W'(1);
                        end
                    end
                end
            end

            default: begin
                w_state_nxt   = S_IDLE;
                w_piezo_nxt   = 1'b0;
                w_piezo_n_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers and FIFO bookkeeping
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_abort) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_per      <= '0;
            r_dur      <= '0;
            r_freq_cnt <= '0;
            r_dur_cnt  <= '0;
            r_piezo    <= 1'b0;
            r_piezo_n  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_per      <= w_per_nxt;
            r_dur      <= w_dur_nxt;
            r_freq_cnt <= w_freq_nxt;
            r_dur_cnt  <= w_dur_cnt_nxt;
            r_piezo    <= w_piezo_nxt;
            r_piezo_n  <= w_piezo_n_nxt;
            r_done     <= w_done_nxt;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset; push is already blocked during rst/clr.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_per[r_wr_ptr] <= note_if.note_per;
            r_mem_dur[r_wr_ptr] <= note_if.note_dur;
        end
    end

    assign piezo     = r_piezo;
    assign piezo_n   = r_piezo_n;
    assign note_done = r_done;
    assign fifo_cnt  = r_cnt;
    assign busy      = (r_state == S_PLAY) || !w_empty;

endmodule
`default_nettype wire

// File: doc/piezo_tone_seq.md
# piezo_tone_seq

Parametrised successor to the piezo note-frequency counter. It accepts a stream of (period, duration) notes through a valid/ready handshake and buffers them in a small FIFO. It plays each note back-to-back on a complementary piezo drive pair, with rests and a synchronous abort, and pulses `note_done` as each note finishes. It sits between the tune/sequence controller and the piezo pins.

## Interface
- `PER_W`, default 15: width of the note half-period field.
- `DUR_W`, default 24: width of the note duration field, in clk cycles.
- `DEPTH`, default 4: FIFO depth in notes. Must be a power of 2 and ≥2.
- `clk`  in  1: system clock (50 MHz). All logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `clr`  in  1: synchronous abort and flush.
- `note_vld`  in  1: a note is offered on `note_per`/`note_dur`.
- `note_rdy`  out  1: the FIFO can accept a note.
- `note_per`  in  PER_W: half-period minus 1, in cycles. 0 means rest.
- `note_dur`  in  DUR_W: note length in cycles. 0 is treated as 1.
- `piezo`  out  1: drive A (registered).
- `piezo_n`  out  1: drive B (registered).
- `busy`  out  1: a note is playing or the FIFO is non-empty.
- `note_done`  out  1: one-cycle pulse at the end of each played note.
- `fifo_cnt`  out  $clog2(DEPTH+1): FIFO occupancy.

## Operation
- **Priority:** `rst` > `clr` > normal operation.
- **FIFO push:** a push occurs on an edge where `note_vld && note_rdy`.
  - `note_rdy = !full && !clr && !rst`, combinational.
  - No push is allowed when full, even if a pop occurs in the same cycle.
- **Simultaneous push and pop:** `fifo_cnt` stays unchanged and the data order is preserved.
- **Pointer width:** pointers are $clog2(DEPTH) bits and wrap naturally.
- **FSM state IDLE:**
  - If the FIFO is non-empty: pop the head, load `per_reg`, `dur_reg`, `freq_cnt=0`, `dur_cnt=1`, and go to PLAY.
  - On that same edge, set `piezo = (per!=0)` and `piezo_n = 0`.
- **FSM state PLAY, non-rest note (`per_reg != 0`):**
  - `freq_cnt` increments each cycle.
  - When `freq_cnt == per_reg`: `freq_cnt <= 0`, `piezo <= ~piezo`, `piezo_n <= piezo`.
  - `piezo_n` is always `~piezo` during a non-rest note.
  - The full tone period is 2·(per_reg+1) cycles.
- **FSM state PLAY, rest note (`per_reg == 0`):** `piezo = piezo_n = 0` for the whole duration.
- **Note end:**
  - PLAY lasts exactly max(`dur_reg`,1) cycles.
  - On the edge where `dur_cnt == max(dur_reg,1)`: go to IDLE, set `piezo <= 0`, `piezo_n <= 0`, `note_done <= 1` for one cycle.
- **Silent state:** both drives are low in IDLE, during rests, and after abort. There is no DC across the piezo.
- **`clr`:**
  - Empties the FIFO (`fifo_cnt <= 0`) and forces IDLE.
  - Sets `piezo = piezo_n = 0`.
  - Does **not** pulse `note_done`.
  - A note offered during `clr` is not accepted.
- **`rst`:** same effect as `clr`; additionally clears `note_done`.
- **Counter widths:**
  - `freq_cnt` is PER_W bits and never exceeds `per_reg`.
  - `dur_cnt` is DUR_W bits and never exceeds `dur_reg`. There is no overflow at `dur_reg` = 2^DUR_W−1.

## Timing
- **Values during and after reset:**
  - `piezo` = 0, `piezo_n` = 0, `note_done` = 0, `busy` = 0, `fifo_cnt` = 0.
  - `note_rdy` = 0 while `rst` is high and 1 on the first cycle after `rst` deasserts.
- **Latency:** for a note accepted at edge E0 into an empty FIFO with the FSM idle:
  - Pop occurs at E1, and the drive is visible after E1.
  - `note_done` is high for the cycle after E1+max(dur,1).
- **Inter-note gap:** back-to-back notes have exactly one silent IDLE cycle between them.
- **`busy`:** registered-equivalent to (state==PLAY || `fifo_cnt`!=0).
  - It drops in the same cycle `note_done` rises, when no notes are queued.
- **Abort timing:** `clr` takes effect on the next edge, with no drain and no partial period.

## Test plan
- **Single tone:** reset, then push per=3, dur=16.
  - `piezo` is high 4 cycles, low 4, high 4, low 4; `piezo_n` is inverted throughout.
  - `note_done` pulses once 17 cycles after acceptance; `busy` then falls.
- **Rest and zero duration:** push per=0, dur=10, then per=1, dur=0.
  - The first note gives both drives low for 10 cycles.
  - The second note gives `piezo` high 1 cycle.
  - There are two `note_done` pulses, separated by 1+1 cycles (IDLE gap plus one PLAY cycle).
- **Full FIFO:** with DEPTH=4, hold `note_vld` while a long note plays.
  - Exactly 4 notes are accepted, then `note_rdy`=0 and `fifo_cnt`=4.
  - `note_rdy` returns to 1 the cycle after the next pop.
  - Notes play in FIFO order.
- **Wrap-around:** push and play 10 notes with distinct per values 1..10.
  - Output half-periods match each per+1 in order.
  - There are 10 `note_done` pulses, each followed by a 1-cycle gap.
- **Mid-note abort:** assert `clr` for 1 cycle in the middle of a note with 2 notes queued.
  - The next cycle has `piezo`=`piezo_n`=0, `fifo_cnt`=0, `busy`=0, and no `note_done`.
  - A fresh push then plays normally.
- **Reset mid-operation:** assert `rst` during PLAY with `note_vld` high.
  - All outputs match their reset values and nothing is accepted while `rst` is high.
  - `note_rdy` is 1 the cycle after `rst` deasserts.
